// File: rtl/adder_16bit_addsub_pkg.sv
// adder_16bit_addsub_pkg: shared width constants and the packed result type
package adder_16bit_addsub_pkg;
  localparam int WIDTH = 16;
  localparam int SLICES = WIDTH / 4;
  typedef struct packed {
    logic o;
    logic c_out;
    logic [WIDTH-1:0] sum;
  } result_t;
endpackage

// File: rtl/adder4_slice.sv
// adder4_slice: 4-bit ripple adder of full-adder cells, exposing the carry into bit 3
module adder4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/adder_16bit_addsub.sv
// adder_16bit_addsub: registered 16-bit add/subtract with carry-out and signed overflow
module adder_16bit_addsub
  import adder_16bit_addsub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add_ctrl,
  output logic [WIDTH-1:0] SUM,
  output logic             C_out,
  output logic             O
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_d;
  logic [SLICES:0] c;
  logic [SLICES-2:0] c3_unused;
  logic c15;
  result_t res_q;
  assign b_eff = B ^ {WIDTH{~Add_ctrl}};
  assign c[0] = ~Add_ctrl;
  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    if (i == SLICES - 1) begin : g_top
      adder4_slice u_slice (
        .a(A[4*i+:4]), .b(b_eff[4*i+:4]), .cin(c[i]),
        .s(sum_d[4*i+:4]), .cout(c[i+1]), .c3(c15)
      );
    end else begin : g_low
      adder4_slice u_slice (
        .a(A[4*i+:4]), .b(b_eff[4*i+:4]), .cin(c[i]),
        .s(sum_d[4*i+:4]), .cout(c[i+1]), .c3(c3_unused[i])
      );
    end
  end
  // capture {O, C_out, SUM}; reset overrides the operation sampled on the same edge
  always_ff @(posedge clk) begin
    res_q <= rst ? '0 : result_t'{o: c[SLICES] ^ c15, c_out: c[SLICES], sum: sum_d};
  end
  assign SUM = res_q.sum;
  assign C_out = res_q.c_out;
  assign O = res_q.o;
endmodule

// File: tb/tb_adder_16bit_addsub.sv
// tb_adder_16bit_addsub: scoreboard bench comparing {O, C_out, SUM} against a reference model
module tb_adder_16bit_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic add_ctrl = 1'b1;
  logic [15:0] sum;
  logic c_out;
  logic o;
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  adder_16bit_addsub dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Add_ctrl(add_ctrl),
    .SUM(sum), .C_out(c_out), .O(o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic add);
    logic [15:0] ye;
    logic [16:0] r;
    logic ov;
    ye = add ? y : ~y;
    r = {1'b0, x} + {1'b0, ye} + {16'd0, ~add};
    ov = (x[15] == ye[15]) && (r[15] != x[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {O,C,SUM}=%0b,%0b,%04h expected %0b,%0b,%04h",
               tag, got[17], got[16], got[15:0], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [15:0] x, input logic [15:0] y, input logic add);
    logic [17:0] e;
    @(negedge clk);
    rst = r;
    a = x;
    b = y;
    add_ctrl = add;
    exp_q.push_back(r ? 18'd0 : model(x, y, add));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {o, c_out, sum}, e);
  endtask

  initial begin
    step("reset0", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    step("reset1", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    step("release", 1'b0, 16'h1234, 16'h0F0F, 1'b1);
    step("add_pos_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b1);
    check("add_pos_ovf_const", {o, c_out, sum}, {1'b1, 1'b0, 16'h8000});
    step("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b1);
    check("add_wrap_const", {o, c_out, sum}, {1'b0, 1'b1, 16'h0000});
    step("sub_5_3", 1'b0, 16'h0005, 16'h0003, 1'b0);
    check("sub_5_3_const", {o, c_out, sum}, {1'b0, 1'b1, 16'h0002});
    step("sub_borrow", 1'b0, 16'h0000, 16'h0001, 1'b0);
    check("sub_borrow_const", {o, c_out, sum}, {1'b0, 1'b0, 16'hFFFF});
    step("sub_neg_ovf", 1'b0, 16'h8000, 16'h0001, 1'b0);
    check("sub_neg_ovf_const", {o, c_out, sum}, {1'b1, 1'b1, 16'h7FFF});
    step("sub_zero_zero", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("sub_zero_zero_const", {o, c_out, sum}, {1'b0, 1'b1, 16'h0000});
    step("sub_a_zero", 1'b0, 16'hA5C3, 16'h0000, 1'b0);
    check("sub_a_zero_const", {o, c_out, sum}, {1'b1, 1'b1, 16'hA5C3} & 18'h1FFFF | {model(16'hA5C3, 16'h0000, 1'b0)} & 18'h20000);
    step("add_neg_ovf", 1'b0, 16'h8000, 16'h8000, 1'b1);
    step("sub_pos_ovf", 1'b0, 16'h7FFF, 16'hFFFF, 1'b0);
    step("mid_reset", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step("after_mid_reset", 1'b0, 16'h0F00, 16'h00F0, 1'b0);
    for (int i = 0; i < 10000; i++)
      step("random", 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
